// File: rtl/pwm_oc_channel_if.sv
// +--------------------------------------------------------------------------+
// | pwm_oc_channel_if : counter, configuration and output bundle for one     |
// | output-compare channel.                  Rev 1.0 - initial release       |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pwm_oc_channel_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cnt_en_i;
  logic [CNT_WIDTH-1:0] cnt_i;
  logic                 overflow_i;
  logic [CNT_WIDTH-1:0] ccr_preload_i;
  logic                 preload_en_i;
  logic [2:0]           oc_mode_i;
  logic                 polarity_i;
  logic                 ch_en_i;
  logic                 idle_level_i;
  logic                 flag_clr_i;
  logic                 pwm_o;
  logic                 match_pulse_o;
  logic                 match_flag_o;
  logic [CNT_WIDTH-1:0] ccr_shadow_o;

  modport master (
    output cnt_en_i, cnt_i, overflow_i, ccr_preload_i, preload_en_i,
           oc_mode_i, polarity_i, ch_en_i, idle_level_i, flag_clr_i,
    input  pwm_o, match_pulse_o, match_flag_o, ccr_shadow_o
  );

  modport slave (
    input  cnt_en_i, cnt_i, overflow_i, ccr_preload_i, preload_en_i,
           oc_mode_i, polarity_i, ch_en_i, idle_level_i, flag_clr_i,
    output pwm_o, match_pulse_o, match_flag_o, ccr_shadow_o
  );
endinterface

`default_nettype wire

// File: rtl/pwm_oc_channel.sv
// +--------------------------------------------------------------------------+
// | pwm_oc_channel : output-compare channel with shadowed CCR, 8 OC modes,   |
// | polarity and idle level.                 Rev 1.0 - initial release       |
// +--------------------------------------------------------------------------+
`default_nettype none

module pwm_oc_channel #(
  parameter int CNT_WIDTH = 16
) (
  input  wire logic        clk_psc_i,
  input  wire logic        rst_n_i,
  pwm_oc_channel_if.slave  oc_if
);

  localparam logic [2:0] MODE_FROZEN  = 3'b000;
  localparam logic [2:0] MODE_SET     = 3'b001;
  localparam logic [2:0] MODE_CLEAR   = 3'b010;
  localparam logic [2:0] MODE_TOGGLE  = 3'b011;
  localparam logic [2:0] MODE_FORCE_0 = 3'b100;
  localparam logic [2:0] MODE_FORCE_1 = 3'b101;
  localparam logic [2:0] MODE_PWM1    = 3'b110;
  localparam logic [2:0] MODE_PWM2    = 3'b111;

  logic [CNT_WIDTH-1:0] ccr_shadow_q, ccr_shadow_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 oc_ref_q, oc_ref_d;
  logic                 pwm_q, pwm_d;
  logic                 match_pulse_q, match_pulse_d;
  logic                 match_flag_q, match_flag_d;
  logic                 match_evt;
  logic                 cnt_below_ccr;

  always_comb begin
    // cnt_q parks at all-ones while stopped so the first count after enable is always new
    match_evt     = oc_if.cnt_en_i && (oc_if.cnt_i == ccr_shadow_q) &&
                    ((oc_if.cnt_i != cnt_q) || oc_if.overflow_i);
    cnt_below_ccr = (oc_if.cnt_i < ccr_shadow_q);

    ccr_shadow_d = ccr_shadow_q;
    if (!oc_if.preload_en_i || oc_if.overflow_i || !oc_if.cnt_en_i) begin
      ccr_shadow_d = oc_if.ccr_preload_i;
    end

    cnt_d = oc_if.cnt_en_i ? oc_if.cnt_i : {CNT_WIDTH{1'b1}};

    oc_ref_d = oc_ref_q;
    case (oc_if.oc_mode_i)
      MODE_FROZEN:  oc_ref_d = oc_ref_q;
      MODE_SET:     if (match_evt) oc_ref_d = 1'b1;
      MODE_CLEAR:   if (match_evt) oc_ref_d = 1'b0;
      MODE_TOGGLE:  if (match_evt) oc_ref_d = ~oc_ref_q;
      MODE_FORCE_0: oc_ref_d = 1'b0;
      MODE_FORCE_1: oc_ref_d = 1'b1;
      MODE_PWM1:    oc_ref_d = oc_if.cnt_en_i &&  cnt_below_ccr;
      MODE_PWM2:    oc_ref_d = oc_if.cnt_en_i && !cnt_below_ccr;
      default:      oc_ref_d = oc_ref_q;
    endcase

    pwm_d         = oc_if.ch_en_i ? (oc_ref_d ^ oc_if.polarity_i) : oc_if.idle_level_i;
    match_pulse_d = match_evt;
    // a new event wins over a coincident clear
    match_flag_d  = match_evt ? 1'b1 : (oc_if.flag_clr_i ? 1'b0 : match_flag_q);
  end

  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) begin
      ccr_shadow_q  <= '0;
      cnt_q         <= {CNT_WIDTH{1'b1}};
      oc_ref_q      <= 1'b0;
      pwm_q         <= 1'b0;
      match_pulse_q <= 1'b0;
      match_flag_q  <= 1'b0;
    end else begin
      ccr_shadow_q  <= ccr_shadow_d;
      cnt_q         <= cnt_d;
      oc_ref_q      <= oc_ref_d;
      pwm_q         <= pwm_d;
      match_pulse_q <= match_pulse_d;
      match_flag_q  <= match_flag_d;
    end
  end

  assign oc_if.pwm_o         = pwm_q;
  assign oc_if.match_pulse_o = match_pulse_q;
  assign oc_if.match_flag_o  = match_flag_q;
  assign oc_if.ccr_shadow_o  = ccr_shadow_q;

endmodule

`default_nettype wire

// File: doc/pwm_oc_channel.md
Name: pwm_oc_channel

Overview:
- Single output-compare channel downstream of pwm_counter. Consumes cnt_o/overflow_o; produces one PWM/compare output pin plus a match flag.
- Holds a preloadable compare register (CCR) with a shadow copy, supports 8 output modes, output polarity and idle level.
- Instantiated once per channel (16× in the PWM bank), all sharing one counter.

Parameters:
CNT_WIDTH, 16, width of counter and CCR values (must match pwm_counter).

Ports:
clk_psc_i  input  1  prescaler-domain clock (same clock as pwm_counter)
rst_n_i  input  1  reset; synchronous, active-low
cnt_en_i  input  1  counter enable (same signal as pwm_counter)
cnt_i  input  CNT_WIDTH  counter value (pwm_counter cnt_o)
overflow_i  input  1  overflow pulse (pwm_counter overflow_o)
ccr_preload_i  input  CNT_WIDTH  compare value from register file
preload_en_i  input  1  1 = CCR shadow updates only at update events; 0 = immediate
oc_mode_i  input  3  output mode (see Behaviour)
polarity_i  input  1  1 = invert reference before pin
ch_en_i  input  1  channel output enable
idle_level_i  input  1  pin level when ch_en_i = 0
flag_clr_i  input  1  clear sticky match flag (1-cycle pulse)
pwm_o  output  1  channel output pin
match_pulse_o  output  1  1-cycle pulse per compare match event
match_flag_o  output  1  sticky match flag
ccr_shadow_o  output  CNT_WIDTH  active (shadow) compare value, readback

Behaviour:
- Reset (rst_n_i = 0 at a clk_psc_i edge):
  - ccr_shadow = 0, oc_ref = 0, cnt_q = all-ones.
  - pwm_o = 0, match_pulse_o = 0, match_flag_o = 0.
  - Reset applied mid-period takes effect at the next edge. No async path.
- CCR shadow update, registered:
  - preload_en_i = 0: ccr_shadow <= ccr_preload_i every cycle.
  - preload_en_i = 1: load only when overflow_i = 1 or cnt_en_i = 0; otherwise hold.
  - The new value is in effect from the cycle after the load.
- Match event (combinational, internal):
  - evt = cnt_en_i && (cnt_i == ccr_shadow) && ((cnt_i != cnt_q) || overflow_i).
  - cnt_q <= cnt_i each cycle while cnt_en_i = 1; cnt_q <= all-ones while cnt_en_i = 0, so a first count of 0 after enable is a new value.
  - Result: exactly one event per counter value visit, including when ARR = 0 (counter stuck at 0, overflow every ck_cnt).
- Reference oc_ref, registered (1-cycle latency from cnt_i/evt):
  - 000 frozen: hold.
  - 001 set-on-match: evt → 1.
  - 010 clear-on-match: evt → 0.
  - 011 toggle-on-match: evt → ~oc_ref.
  - 100 force inactive: 0.
  - 101 force active: 1.
  - 110 PWM1: cnt_en_i ? (cnt_i < ccr_shadow) : 0.
  - 111 PWM2: cnt_en_i ? ~(cnt_i < ccr_shadow) : 0.
  - Comparison is unsigned, full CNT_WIDTH.
  - PWM1 with CCR = 0 → constant 0. PWM1 with CCR > ARR → constant 1 while counting.
  - Mode change takes effect at the next edge. oc_ref is not reset on a mode change.
- Output: pwm_o <= ch_en_i ? (oc_ref_next ^ polarity_i) : idle_level_i.
  - Registered in the same edge as oc_ref, so pwm_o lags cnt_i by exactly 1 cycle.
  - ch_en_i and polarity_i changes are visible 1 cycle later.
- match_pulse_o <= evt, in all modes including force and frozen.
- match_flag_o <= evt ? 1 : (flag_clr_i ? 0 : match_flag_o). Set wins over a simultaneous clear.
- cnt_en_i = 0:
  - No events.
  - Match modes hold oc_ref; force modes still apply; PWM modes drive oc_ref = 0.
  - Shadow loads freely.

Test Plan:
1. Reset: hold rst_n_i = 0 with ch_en_i = 1, mode = PWM1, CCR = 5 → pwm_o = 0, flags = 0, ccr_shadow_o = 0. Release → after enable, PWM starts correctly.
2. PWM1, ARR = 9, CCR = 3, preload on, polarity 0 → pwm_o high for 3 of 10 counts, lagging cnt by 1 clk. Polarity 1 → inverted waveform.
3. Preload: CCR 3 → 7 written mid-period with preload_en_i = 1 → duty changes only after the next overflow_i. With preload_en_i = 0 → takes effect 1 cycle after write.
4. Boundaries, PWM1 with ARR = 9:
   - CCR = 0 → pwm_o constant 0.
   - CCR = 10 → constant 1.
   - ARR = 0, CCR = 0, toggle mode → pwm_o toggles on each overflow.
5. Toggle mode, CCR = 4, ARR = 9 → one match_pulse_o per period at cnt = 4. match_flag_o sets; flag_clr_i on the same cycle as the next event → flag stays 1.
6. ch_en_i = 0, idle_level_i = 1 → pwm_o = 1 regardless of mode. Force-active mode with ch_en_i = 1, polarity 1 → pwm_o = 0. Disable cnt_en_i in PWM2 → pwm_o goes to 0 ^ polarity.
